multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle sequencer for the MIPS-subset CPU. It replaces single-cycle decode with a Moore FSM that steps each instruction through IF/ID/EXE/MEM/WB. It drives PC update, instruction-memory read enable, register file, ALU, data memory and writeback mux controls. It consumes the opcode produced by the instruction memory and the ALU zero flag.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low; forces FSM to IF
- opCode  in  6  opcode field from instruction memory; sampled at end of IF
- zero  in  1  ALU zero flag, valid during branch EXE
- InsMemRW  out  1  0 = instruction memory read enabled (IF), 1 = hold
- IRWre  out  1  instruction-register load enable
- PCWre  out  1  PC write enable, one pulse per retired instruction
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(sext(imm)<<2)
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 011 or, 100 and
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- RegDst  out  1  0 = rt, 1 = rd
- RegWre  out  1  register-file write enable
- DBDataSrc  out  1  0 = ALU result, 1 = data-memory output
- mRD, mWR  out  1 each  data-memory read / write strobes
- state  out  4  current FSM state, for debug
- halted  out  1  high while in HALT
- instr_count  out  16  count of retired instructions

## Operation
- Opcodes: add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, move 100000, sw 100110, lw 100111, beq 110000, halt 111111. All other opcodes are illegal.
- op_q register: loaded from opCode on the clock edge leaving IF. All decode uses op_q, never the live opCode.
- States: IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8.
- Transitions:
  - IF→ID always.
  - ID→EXE_AL for add/addi/sub/ori/and/or/move.
  - ID→EXE_BR for beq.
  - ID→EXE_LS for lw/sw.
  - ID→HALT for halt.
  - ID→IF for illegal opcodes (treated as NOP).
  - EXE_AL→WB_AL→IF.
  - EXE_BR→IF.
  - EXE_LS→MEM.
  - MEM→IF for sw; MEM→WB_LD for lw.
  - WB_LD→IF.
  - HALT→HALT until Reset.
- Outputs are combinational from (state, op_q, zero). Every signal not listed below is 0, except InsMemRW, which defaults to 1.
  - IF: InsMemRW=0, IRWre=1.
  - EXE_AL / WB_AL:
    - ALUOp: sub→001, or/ori→011, and→100, else 000. Move is add with rt=$0.
    - ALUSrcB=1 for addi/ori.
    - ExtSel=1 except ori.
    - RegDst=1 for add/sub/and/or/move.
  - WB_AL: RegWre=1, PCWre=1.
  - EXE_BR: ALUOp=001, ExtSel=1, PCWre=1, PCSrc=01 if zero else 00.
  - EXE_LS / MEM / WB_LD: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - MEM: mRD=1 for lw; mWR=1 and PCWre=1 for sw.
  - WB_LD: DBDataSrc=1, RegDst=0, RegWre=1, PCWre=1.
  - ID with illegal opcode: PCWre=1, PCSrc=00.
  - HALT: all strobes 0, halted=1.
- instr_count increments by 1 on each edge where PCWre=1. It wraps from 0xFFFF to 0x0000.

## Timing
- Reset low, asynchronous: state=IF, op_q=0, instr_count=0. With state=IF, outputs read InsMemRW=0 and IRWre=1, all others 0.
- Reset release: the first IF occupies the first full cycle.
- Cycle counts per instruction: ALU ops 4, beq 3, sw 4, lw 5, illegal 2, halt 2 then stall.
- PCWre is high for exactly one cycle per instruction, always in its final state. The PC changes on that edge, and the next state is IF.
- zero is sampled combinationally during EXE_BR only. Glitches on zero in other states have no effect.
- mRD/mWR are never high in the same cycle as RegWre.
- Reset asserted mid-instruction: immediate abort, no partial writes. Strobes drop asynchronously.

## Test plan
- Reset, then addi (000001): states 0,1,2,3,0. RegWre and PCWre high only in state 3 with ALUSrcB=1, ExtSel=1, RegDst=0. instr_count=1.
- beq with zero=1, then beq with zero=0: 3 cycles each. PCSrc=01 in the first EXE_BR and 00 in the second. PCWre is high one cycle each.
- lw then sw: lw gives states 0,1,5,6,7 with mRD in 6 and DBDataSrc=1, RegWre=1 in 7. sw gives 0,1,5,6 with mWR=1, PCWre=1 in 6 and RegWre never high.
- halt (111111): state reaches 8 after 2 cycles. halted=1, PCWre stays 0 for 20 cycles, and opCode changes are ignored. Asserting Reset returns to IF.
- Illegal opcode 001111: IF→ID→IF, PCWre high in ID, RegWre/mWR never high. Then ori (010000) decodes with ExtSel=0, ALUOp=011.
- Reset pulsed during MEM of sw: mWR falls in the same cycle, state=0 and instr_count=0 with no clock edge. Also preload instr_count near 0xFFFF via a run of ALU ops and confirm it wraps to 0x0000.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if
//
// Bundles the signals between the multi-cycle sequencer and the datapath it
// steers. The sequencer uses the master modport. The datapath, or a bench
// standing in for it, uses the slave modport.
//
// Signals:
//   opCode       opcode field from instruction memory (datapath -> sequencer)
//   zero         ALU zero flag                        (datapath -> sequencer)
//   InsMemRW     0 = instruction memory read enabled, 1 = hold
//   IRWre        instruction-register load enable
//   PCWre        PC write enable, one pulse per retired instruction
//   PCSrc        00 = PC+4, 01 = PC+4+(sext(imm)<<2)
//   ALUSrcB      0 = rt data, 1 = extended immediate
//   ALUOp        000 add, 001 sub, 011 or, 100 and
//   ExtSel       0 = zero-extend, 1 = sign-extend
//   RegDst       0 = rt, 1 = rd
//   RegWre       register-file write enable
//   DBDataSrc    0 = ALU result, 1 = data-memory output
//   mRD, mWR     data-memory read / write strobes
//   state        current sequencer state (debug)
//   halted       high while halted
//   instr_count  number of retired instructions (wraps)
interface multicycle_control_unit_if;
    logic [5:0]  opCode;
    logic        zero;
    logic        InsMemRW;
    logic        IRWre;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        ALUSrcB;
    logic [2:0]  ALUOp;
    logic        ExtSel;
    logic        RegDst;
    logic        RegWre;
    logic        DBDataSrc;
    logic        mRD;
    logic        mWR;
    logic [3:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        input  opCode, zero,
        output InsMemRW, IRWre, PCWre, PCSrc, ALUSrcB, ALUOp, ExtSel,
               RegDst, RegWre, DBDataSrc, mRD, mWR, state, halted, instr_count
    );

    modport slave (
        output opCode, zero,
        input  InsMemRW, IRWre, PCWre, PCSrc, ALUSrcB, ALUOp, ExtSel,
               RegDst, RegWre, DBDataSrc, mRD, mWR, state, halted, instr_count
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Moore sequencer for the multi-cycle MIPS-subset CPU. Each instruction is
// stepped through IF / ID / EXE / MEM / WB. The sequencer drives the PC,
// instruction memory, register file, ALU, data memory and writeback mux
// controls.
//
// Ports:
//   CLK    system clock, rising edge
//   Reset  asynchronous, active-low. Returns the sequencer to IF.
//   bus    multicycle_control_unit_if.master. It carries opCode and zero in,
//          and all control strobes plus the debug state, halted flag and
//          retired-instruction count out.
module multicycle_control_unit (
    input  logic                             CLK,
    input  logic                             Reset,
    multicycle_control_unit_if.master        bus
);

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_WB_AL  = 4'd3,
        ST_EXE_BR = 4'd4,
        ST_EXE_LS = 4'd5,
        ST_MEM    = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t      state_q;
    state_t      next_state;
    logic [5:0]  op_q;
    logic [15:0] count_q;

    logic        is_alu;
    logic        is_beq;
    logic        is_mem;
    logic        is_lw;
    logic        is_halt;

    logic        ins_mem_rw;
    logic        ir_wre;
    logic        pc_wre;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [2:0]  alu_op;
    logic        ext_sel;
    logic        reg_dst;
    logic        reg_wre;
    logic        db_data_src;
    logic        m_rd;
    logic        m_wr;
    logic        halted;

    // The opcode is captured as the sequencer leaves IF. After that point the
    // live opCode may change freely, because only op_q is decoded.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IF;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == ST_IF) begin
                op_q <= bus.opCode;
            end
            if (pc_wre) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    // Instruction class decode of the latched opcode. An opcode that matches
    // no class is illegal and is retired as a NOP directly from ID.
    always_comb begin
        is_alu  = 1'b0;
        is_beq  = 1'b0;
        is_mem  = 1'b0;
        is_lw   = 1'b0;
        is_halt = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
            OP_AND, OP_OR, OP_MOVE:        is_alu  = 1'b1;
            OP_BEQ:                        is_beq  = 1'b1;
            OP_SW:                         is_mem  = 1'b1;
            OP_LW: begin
                is_mem = 1'b1;
                is_lw  = 1'b1;
            end
            OP_HALT:                       is_halt = 1'b1;
            default: ;
        endcase
    end

    // Next state and Moore outputs. Every state that retires an instruction
    // raises pc_wre and returns to IF, so the count advances once per
    // instruction. zero is only looked at in EXE_BR.
    always_comb begin
        next_state  = state_q;
        ins_mem_rw  = 1'b1;
        ir_wre      = 1'b0;
        pc_wre      = 1'b0;
        pc_src      = 2'b00;
        alu_src_b   = 1'b0;
        alu_op      = 3'b000;
        ext_sel     = 1'b0;
        reg_dst     = 1'b0;
        reg_wre     = 1'b0;
        db_data_src = 1'b0;
        m_rd        = 1'b0;
        m_wr        = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IF: begin
                ins_mem_rw = 1'b0;
                ir_wre     = 1'b1;
                next_state = ST_ID;
            end
            ST_ID: begin
                if (is_alu) begin
                    next_state = ST_EXE_AL;
                end else if (is_beq) begin
                    next_state = ST_EXE_BR;
                end else if (is_mem) begin
                    next_state = ST_EXE_LS;
                end else if (is_halt) begin
                    next_state = ST_HALT;
                end else begin
                    pc_wre     = 1'b1;
                    next_state = ST_IF;
                end
            end
            ST_EXE_AL, ST_WB_AL: begin
                // move is executed as add with rt = $0
                case (op_q)
                    OP_SUB:        alu_op = 3'b001;
                    OP_OR, OP_ORI: alu_op = 3'b011;
                    OP_AND:        alu_op = 3'b100;
                    default:       alu_op = 3'b000;
                endcase
                alu_src_b = (op_q == OP_ADDI) || (op_q == OP_ORI);
                ext_sel   = (op_q != OP_ORI);
                reg_dst   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                            (op_q == OP_AND) || (op_q == OP_OR)  ||
                            (op_q == OP_MOVE);
                if (state_q == ST_WB_AL) begin
                    reg_wre    = 1'b1;
                    pc_wre     = 1'b1;
                    next_state = ST_IF;
                end else begin
                    next_state = ST_WB_AL;
                end
            end
            ST_EXE_BR: begin
                alu_op     = 3'b001;
                ext_sel    = 1'b1;
                pc_wre     = 1'b1;
                pc_src     = bus.zero ? 2'b01 : 2'b00;
                next_state = ST_IF;
            end
            ST_EXE_LS: begin
                alu_src_b  = 1'b1;
                ext_sel    = 1'b1;
                next_state = ST_MEM;
            end
            ST_MEM: begin
                alu_src_b = 1'b1;
                ext_sel   = 1'b1;
                if (is_lw) begin
                    m_rd       = 1'b1;
                    next_state = ST_WB_LD;
                end else begin
                    m_wr       = 1'b1;
                    pc_wre     = 1'b1;
                    next_state = ST_IF;
                end
            end
            ST_WB_LD: begin
                alu_src_b   = 1'b1;
                ext_sel     = 1'b1;
                db_data_src = 1'b1;
                reg_wre     = 1'b1;
                pc_wre      = 1'b1;
                next_state  = ST_IF;
            end
            ST_HALT: begin
                halted     = 1'b1;
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IF;
            end
        endcase
    end

    assign bus.InsMemRW    = ins_mem_rw;
    assign bus.IRWre       = ir_wre;
    assign bus.PCWre       = pc_wre;
    assign bus.PCSrc       = pc_src;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.ExtSel      = ext_sel;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWre      = reg_wre;
    assign bus.DBDataSrc   = db_data_src;
    assign bus.mRD         = m_rd;
    assign bus.mWR         = m_wr;
    assign bus.state       = state_q;
    assign bus.halted      = halted;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//
// Bench for the multi-cycle sequencer. When an instruction is issued, the
// stimulus side builds the full expected per-cycle control word for it from
// an instruction-level model and queues it. A monitor pops one entry on each
// falling clock edge and compares it against the outputs. Asynchronous reset
// behaviour is checked directly.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_ILL  = 6'b001111;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_SW   = 2;
    localparam int K_LW   = 3;
    localparam int K_HALT = 4;
    localparam int K_ILL  = 5;

    typedef struct packed {
        logic [3:0]  state;
        logic        ins_mem_rw;
        logic        ir_wre;
        logic        pc_wre;
        logic [1:0]  pc_src;
        logic        alu_src_b;
        logic [2:0]  alu_op;
        logic        ext_sel;
        logic        reg_dst;
        logic        reg_wre;
        logic        db_data_src;
        logic        m_rd;
        logic        m_wr;
        logic        halted;
        logic [15:0] instr_count;
    } exp_t;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;

    multicycle_control_unit_if bus();

    multicycle_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [15:0] model_count = 16'd0;

    logic [5:0]  legal_ops [10];

    function automatic int op_kind(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
            OP_AND, OP_OR, OP_MOVE: return K_ALU;
            OP_BEQ:                 return K_BR;
            OP_SW:                  return K_SW;
            OP_LW:                  return K_LW;
            OP_HALT:                return K_HALT;
            default:                return K_ILL;
        endcase
    endfunction

    function automatic int op_len(input logic [5:0] op);
        case (op_kind(op))
            K_ALU:   return 4;
            K_BR:    return 3;
            K_SW:    return 4;
            K_LW:    return 5;
            K_HALT:  return 2;
            default: return 2;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction, with k = 0 being
    // its fetch cycle. The retiring cycle is always the last one.
    function automatic exp_t model_cycle(input logic [5:0] op, input int k,
                                         input logic zbr, input logic [15:0] cnt);
        exp_t e;
        int   kind;
        kind          = op_kind(op);
        e             = '0;
        e.ins_mem_rw  = 1'b1;
        e.instr_count = cnt;
        if (k == 0) begin
            e.state      = 4'd0;
            e.ins_mem_rw = 1'b0;
            e.ir_wre     = 1'b1;
        end else if (k == 1) begin
            e.state  = 4'd1;
            e.pc_wre = (kind == K_ILL);
        end else begin
            case (kind)
                K_ALU: begin
                    e.state     = (k == 2) ? 4'd2 : 4'd3;
                    e.alu_op    = (op == OP_SUB) ? 3'b001 :
                                  (op == OP_OR || op == OP_ORI) ? 3'b011 :
                                  (op == OP_AND) ? 3'b100 : 3'b000;
                    e.alu_src_b = (op == OP_ADDI || op == OP_ORI);
                    e.ext_sel   = (op != OP_ORI);
                    e.reg_dst   = (op == OP_ADD || op == OP_SUB || op == OP_AND ||
                                   op == OP_OR || op == OP_MOVE);
                    e.reg_wre   = (k == 3);
                    e.pc_wre    = (k == 3);
                end
                K_BR: begin
                    e.state   = 4'd4;
                    e.alu_op  = 3'b001;
                    e.ext_sel = 1'b1;
                    e.pc_wre  = 1'b1;
                    e.pc_src  = zbr ? 2'b01 : 2'b00;
                end
                K_SW, K_LW: begin
                    e.state     = (k == 2) ? 4'd5 : (k == 3) ? 4'd6 : 4'd7;
                    e.alu_src_b = 1'b1;
                    e.ext_sel   = 1'b1;
                    if (k == 3) begin
                        e.m_rd   = (kind == K_LW);
                        e.m_wr   = (kind == K_SW);
                        e.pc_wre = (kind == K_SW);
                    end
                    if (k == 4) begin
                        e.db_data_src = 1'b1;
                        e.reg_wre     = 1'b1;
                        e.pc_wre      = 1'b1;
                    end
                end
                default: begin
                    e.state  = 4'd8;
                    e.halted = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    function automatic exp_t sample_dut();
        exp_t a;
        a.state       = bus.state;
        a.ins_mem_rw  = bus.InsMemRW;
        a.ir_wre      = bus.IRWre;
        a.pc_wre      = bus.PCWre;
        a.pc_src      = bus.PCSrc;
        a.alu_src_b   = bus.ALUSrcB;
        a.alu_op      = bus.ALUOp;
        a.ext_sel     = bus.ExtSel;
        a.reg_dst     = bus.RegDst;
        a.reg_wre     = bus.RegWre;
        a.db_data_src = bus.DBDataSrc;
        a.m_rd        = bus.mRD;
        a.m_wr        = bus.mWR;
        a.halted      = bus.halted;
        a.instr_count = bus.instr_count;
        return a;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        checks++;
        if (act === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Issue one instruction, or its first ncyc cycles when ncyc > 0. opCode
    // and zero are scrambled in every cycle where they should be ignored.
    task automatic apply_stimulus(input logic [5:0] op, input logic zbr, input int ncyc);
        int len;
        int n;
        int kind;
        len  = op_len(op);
        kind = op_kind(op);
        n    = (ncyc > 0 && ncyc < len) ? ncyc : len;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_cycle(op, k, zbr, model_count));
        end
        for (int k = 0; k < n; k++) begin
            bus.opCode = (k == 0) ? op : 6'($urandom);
            bus.zero   = (kind == K_BR && k == 2) ? zbr : 1'($urandom);
            @(posedge CLK);
            #1;
        end
        if (n == len && kind != K_HALT) begin
            model_count = model_count + 16'd1;
        end
    endtask

    task automatic halt_stall(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_cycle(OP_HALT, 2, 1'b0, model_count));
        end
        for (int k = 0; k < n; k++) begin
            bus.opCode = 6'($urandom);
            bus.zero   = 1'($urandom);
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [5:0] random_op();
        logic [5:0] op;
        int         idx;
        idx = $urandom_range(0, 10);
        if (idx < 10) begin
            op = legal_ops[idx];
        end else begin
            op = 6'($urandom);
            if (op_kind(op) != K_ILL) begin
                op = OP_ILL;
            end
        end
        return op;
    endfunction

    // Monitor: one expected control word per clock while the queue holds any.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample_dut();
                checks++;
                if (a === e) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL cycle_word (state %0d) at %0t: got %h, want %h",
                             e.state, $time, a, e);
                end
            end
        end
    end

    initial begin
        legal_ops[0] = OP_ADD;  legal_ops[1] = OP_ADDI; legal_ops[2] = OP_SUB;
        legal_ops[3] = OP_ORI;  legal_ops[4] = OP_AND;  legal_ops[5] = OP_OR;
        legal_ops[6] = OP_MOVE; legal_ops[7] = OP_SW;   legal_ops[8] = OP_LW;
        legal_ops[9] = OP_BEQ;

        bus.opCode = OP_HALT;
        bus.zero   = 1'b1;

        // Outputs held in reset look like IF with a zero count.
        @(posedge CLK);
        #1;
        exp_q.push_back(model_cycle(OP_ADD, 0, 1'b0, 16'd0));
        exp_q.push_back(model_cycle(OP_ADD, 0, 1'b0, 16'd0));
        @(posedge CLK);
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        // Directed sequence.
        apply_stimulus(OP_ADDI, 1'b0, 0);
        apply_stimulus(OP_BEQ,  1'b1, 0);
        apply_stimulus(OP_BEQ,  1'b0, 0);
        apply_stimulus(OP_LW,   1'b0, 0);
        apply_stimulus(OP_SW,   1'b0, 0);
        apply_stimulus(OP_ILL,  1'b0, 0);
        apply_stimulus(OP_ORI,  1'b0, 0);
        apply_stimulus(OP_MOVE, 1'b0, 0);

        // Random mix, including illegal opcodes.
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(random_op(), 1'($urandom), 0);
        end

        // Counter wrap: preload near the top, then retire across 0xFFFF.
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        model_count = 16'hFFFE;
        apply_stimulus(OP_ADD, 1'b0, 0);
        apply_stimulus(OP_SUB, 1'b0, 0);
        apply_stimulus(OP_AND, 1'b0, 0);
        check_output("count_after_wrap", 32'(bus.instr_count), 32'h0001);

        // Abort a store in MEM. The write strobe and state drop without a clock.
        apply_stimulus(OP_SW, 1'b0, 3);
        #1;
        check_output("sw_mem_state", 32'(bus.state), 32'd6);
        check_output("sw_mem_mwr", 32'(bus.mWR), 32'd1);
        Reset = 1'b0;
        #1;
        check_output("abort_mwr", 32'(bus.mWR), 32'd0);
        check_output("abort_state", 32'(bus.state), 32'd0);
        check_output("abort_count", 32'(bus.instr_count), 32'd0);
        check_output("abort_irwre", 32'(bus.IRWre), 32'd1);
        model_count = 16'd0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(random_op(), 1'($urandom), 0);
        end

        // Halt, stall with a busy opCode, then leave through reset.
        apply_stimulus(OP_HALT, 1'b0, 0);
        halt_stall(20);
        #1;
        Reset = 1'b0;
        #1;
        check_output("halt_reset_state", 32'(bus.state), 32'd0);
        check_output("halt_reset_halted", 32'(bus.halted), 32'd0);
        check_output("halt_reset_insmem", 32'(bus.InsMemRW), 32'd0);
        model_count = 16'd0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        apply_stimulus(OP_ADDI, 1'b0, 0);
        apply_stimulus(OP_OR,   1'b0, 0);

        // Let the monitor drain what is left, within a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
        end
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
